oam_dma_ctrl: RTL and testbench

Sequencer and arbiter for the PPU register port. It passes CPU register accesses through when idle. On a one-cycle start strobe (a CPU write to $4014) it halts the CPU via `cpu_rdy` and copies DMA_LEN bytes from CPU page `{dma_page, 8'h00}` into OAMDATA using the NES get/put cycle alignment. It sits in the CPU clock domain between the CPU/PPU_driver bus and the PPU register interface.

---
 rtl/oam_dma_ctrl.sv | 129 ++++++++++++
 tb/tb_oam_dma_ctrl.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/oam_dma_ctrl.sv
// OAM DMA sequencer: halts the CPU, copies one page into OAMDATA with get/put
// alignment, and otherwise passes CPU register accesses through to the PPU.
module oam_dma_ctrl #(
  parameter int unsigned DMA_LEN     = 256,
  parameter logic [2:0]  OAMDATA_REG = 3'd4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        dma_start,
  input  logic [7:0]  dma_page,
  input  logic [2:0]  cpu_ppu_address,
  input  logic [7:0]  cpu_ppu_wdata,
  input  logic        cpu_ppu_cs,
  input  logic        cpu_ppu_rw,
  input  logic [7:0]  mem_rdata,
  output logic        cpu_rdy,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  output logic [2:0]  ppu_address,
  output logic [7:0]  ppu_wdata,
  output logic        ppu_cs,
  output logic        ppu_rw,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {
    IDLE,
    HALT,
    ALIGN,
    READ,
    WRITE
  } state_t;

  localparam logic [7:0] LAST_IDX = 8'(DMA_LEN - 1);

  state_t     state;
  logic       par;
  logic [7:0] idx;
  logic [7:0] page_q;
  logic       busy_q;
  logic       done_q;

  // busy_q is updated alongside every state change so cpu_rdy/busy come from
  // a single flop rather than a decode of the state vector.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      par    <= 1'b0;
      idx    <= '0;
      page_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      par    <= ~par;
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (dma_start) begin
            page_q <= dma_page;
            idx    <= '0;
            busy_q <= 1'b1;
            state  <= HALT;
          end
        end
        HALT: begin
          // par==1 now means the following cycle is a get cycle
          state <= par ? READ : ALIGN;
        end
        ALIGN: begin
          state <= READ;
        end
        READ: begin
          state <= WRITE;
        end
        WRITE: begin
          if (idx == LAST_IDX) begin
            idx    <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            state  <= IDLE;
          end else begin
            idx   <= idx + 8'd1;
            state <= READ;
          end
        end
        default: begin
          busy_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign busy    = busy_q;
  assign cpu_rdy = ~busy_q;
  assign done    = done_q;

  always_comb begin
    mem_rd      = 1'b0;
    mem_addr    = '0;
    ppu_cs      = 1'b0;
    ppu_rw      = 1'b1;
    ppu_address = '0;
    ppu_wdata   = '0;
    case (state)
      IDLE, HALT: begin
        ppu_cs      = cpu_ppu_cs;
        ppu_rw      = cpu_ppu_rw;
        ppu_address = cpu_ppu_address;
        ppu_wdata   = cpu_ppu_wdata;
      end
      READ: begin
        mem_rd   = 1'b1;
        mem_addr = {page_q, idx};
      end
      WRITE: begin
        ppu_cs      = 1'b1;
        ppu_rw      = 1'b0;
        ppu_address = OAMDATA_REG;
        ppu_wdata   = mem_rdata;
      end
      default: begin
        ppu_cs = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Randomized bench for oam_dma_ctrl: a cycle-offset schedule model predicts
// every output each cycle, plus literal checks on transfer-level totals.
module tb_oam_dma_ctrl;

  localparam int unsigned DMA_LEN = 256;
  localparam int unsigned SPAN    = 2 * DMA_LEN;

  logic        clk = 1'b0;
  logic        reset;
  logic        dma_start;
  logic [7:0]  dma_page;
  logic [2:0]  cpu_ppu_address;
  logic [7:0]  cpu_ppu_wdata;
  logic        cpu_ppu_cs;
  logic        cpu_ppu_rw;
  logic [7:0]  mem_rdata;
  logic        cpu_rdy;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic [2:0]  ppu_address;
  logic [7:0]  ppu_wdata;
  logic        ppu_cs;
  logic        ppu_rw;
  logic        busy;
  logic        done;

  always #5 clk = ~clk;

  oam_dma_ctrl #(.DMA_LEN(DMA_LEN), .OAMDATA_REG(3'd4)) dut (
    .clk(clk), .reset(reset), .dma_start(dma_start), .dma_page(dma_page),
    .cpu_ppu_address(cpu_ppu_address), .cpu_ppu_wdata(cpu_ppu_wdata),
    .cpu_ppu_cs(cpu_ppu_cs), .cpu_ppu_rw(cpu_ppu_rw), .mem_rdata(mem_rdata),
    .cpu_rdy(cpu_rdy), .mem_addr(mem_addr), .mem_rd(mem_rd),
    .ppu_address(ppu_address), .ppu_wdata(ppu_wdata), .ppu_cs(ppu_cs),
    .ppu_rw(ppu_rw), .busy(busy), .done(done)
  );

  // memory: one-cycle latency, data = low address byte ^ 5A
  always @(posedge clk) mem_rdata <= mem_addr[7:0] ^ 8'h5A;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  // model: t = cycle index since reset (parity = t%2); a transfer is a fixed
  // schedule of offsets from its HALT cycle h
  int unsigned t = 0;
  bit          act = 1'b0;
  int unsigned h = 0;
  int unsigned al = 0;
  logic [7:0]  pg = '0;
  bit          done_exp = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      t = 0; act = 1'b0; done_exp = 1'b0; pg = '0;
    end else begin
      bit start_now, fin;
      start_now = !act && dma_start;
      fin       = act && ((t - h) == al + SPAN);
      t = t + 1;
      done_exp = fin;
      if (fin) act = 1'b0;
      if (start_now) begin
        act = 1'b1; h = t; al = ((h % 2) == 0) ? 1 : 0; pg = dma_page;
      end
    end
  end

  int unsigned off, k;
  logic        e_rdy, e_busy, e_done, e_rd, e_cs, e_rw;
  logic [15:0] e_addr;
  logic [2:0]  e_pa;
  logic [7:0]  e_wd;

  always @(negedge clk) begin
    if (chk_en) begin
      e_rdy = 1'b1; e_busy = 1'b0; e_done = done_exp; e_rd = 1'b0; e_addr = '0;
      e_cs = cpu_ppu_cs; e_rw = cpu_ppu_rw; e_pa = cpu_ppu_address; e_wd = cpu_ppu_wdata;
      if (act) begin
        off = t - h;
        e_rdy = 1'b0; e_busy = 1'b1; e_done = 1'b0;
        if (off != 0) begin
          e_cs = 1'b0; e_rw = 1'b1; e_pa = '0; e_wd = '0;
          if (!(al == 1 && off == 1)) begin
            k = off - 1 - al;
            if ((k % 2) == 0) begin
              e_rd = 1'b1; e_addr = {pg, 8'(k / 2)};
            end else begin
              e_cs = 1'b1; e_rw = 1'b0; e_pa = 3'd4; e_wd = 8'(k / 2) ^ 8'h5A;
            end
          end
        end
      end
      checks++;
      if ({cpu_rdy, busy, done, mem_rd, mem_addr, ppu_cs, ppu_rw, ppu_address, ppu_wdata} !==
          {e_rdy, e_busy, e_done, e_rd, e_addr, e_cs, e_rw, e_pa, e_wd}) begin
        errors++;
        $display("FAIL cycle t=%0d: got rdy=%b busy=%b done=%b rd=%b addr=%h cs=%b rw=%b ra=%0d wd=%h; want rdy=%b busy=%b done=%b rd=%b addr=%h cs=%b rw=%b ra=%0d wd=%h",
                 t, cpu_rdy, busy, done, mem_rd, mem_addr, ppu_cs, ppu_rw, ppu_address, ppu_wdata,
                 e_rdy, e_busy, e_done, e_rd, e_addr, e_cs, e_rw, e_pa, e_wd);
      end
    end
  end

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_cpu(input bit hold_cs);
    cpu_ppu_address = 3'($urandom);
    cpu_ppu_wdata   = 8'($urandom);
    cpu_ppu_rw      = 1'($urandom);
    cpu_ppu_cs      = hold_cs ? 1'b1 : 1'($urandom);
  endtask

  int unsigned low_cnt, wr_cnt, rd_cnt, done_cnt, align_cnt, rd_cs_cnt;
  int unsigned first_wd, second_wd, last_wd, first_addr, last_addr, first_rd_par;
  bit          halt_cs;

  // start a transfer whose HALT lands on parity halt_par, observe until the
  // CPU is released; optionally re-pulse start at write #inject and on the
  // final write, or assert reset during write #rst_at
  task automatic xfer(input logic [7:0] page, input bit halt_par, input int unsigned inject,
                      input int unsigned rst_at, input bit hold_cs);
    bit finished;
    low_cnt = 0; wr_cnt = 0; rd_cnt = 0; done_cnt = 0; align_cnt = 0; rd_cs_cnt = 0;
    first_wd = 0; second_wd = 0; last_wd = 0; first_addr = 0; last_addr = 0;
    first_rd_par = 2; halt_cs = 1'b0; finished = 1'b0;
    if (((t + 1) % 2) != halt_par) begin
      rand_cpu(hold_cs);
      tick();
    end
    dma_start = 1'b1; dma_page = page; rand_cpu(hold_cs);
    tick();
    for (int n = 0; n < 1200 && !finished; n++) begin
      dma_start = 1'b0; dma_page = 8'($urandom);
      if (cpu_rdy) begin
        finished = 1'b1;
        if (done) done_cnt++;
      end else begin
        low_cnt++;
        if (n == 0) halt_cs = ppu_cs;
        else if (mem_rd) begin
          if (rd_cnt == 0) begin first_addr = mem_addr; first_rd_par = t % 2; end
          last_addr = mem_addr;
          rd_cnt++;
          if (ppu_cs) rd_cs_cnt++;
        end else if (ppu_cs) begin
          wr_cnt++;
          if (wr_cnt == 1) first_wd = ppu_wdata;
          if (wr_cnt == 2) second_wd = ppu_wdata;
          last_wd = ppu_wdata;
          if (inject != 0 && (wr_cnt == inject || wr_cnt == DMA_LEN)) dma_start = 1'b1;
          if (rst_at != 0 && wr_cnt == rst_at) reset = 1'b1;
        end else align_cnt++;
        rand_cpu(hold_cs);
        tick();
      end
    end
    if (!finished) chk("xfer_timeout", 0, 1);
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int n = 0; n < 1200 && !ok; n++) begin
      if (cpu_rdy) ok = 1'b1;
      else begin rand_cpu(1'b0); tick(); end
    end
    if (!ok) chk("wait_idle_timeout", 0, 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: got timeout, want completion");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; dma_start = 1'b0; dma_page = '0;
    cpu_ppu_address = '0; cpu_ppu_wdata = '0; cpu_ppu_cs = 1'b0; cpu_ppu_rw = 1'b1;
    repeat (3) tick();
    chk_en = 1'b1;
    chk("rst_cpu_rdy", int'(cpu_rdy), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_mem_rd", int'(mem_rd), 0);
    chk("rst_mem_addr", int'(mem_addr), 0);
    reset = 1'b0;

    cpu_ppu_address = 3'd2; cpu_ppu_cs = 1'b1; cpu_ppu_rw = 1'b0; cpu_ppu_wdata = 8'hA5;
    #1;
    chk("idle_pt_addr", int'(ppu_address), 2);
    chk("idle_pt_cs", int'(ppu_cs), 1);
    chk("idle_pt_rw", int'(ppu_rw), 0);
    chk("idle_pt_wdata", int'(ppu_wdata), 'hA5);
    tick();

    // HALT on put cycle: no ALIGN
    xfer(8'h02, 1'b1, 0, 0, 1'b0);
    chk("x1_low", int'(low_cnt), 513);
    chk("x1_writes", int'(wr_cnt), 256);
    chk("x1_reads", int'(rd_cnt), 256);
    chk("x1_first_wd", int'(first_wd), 'h5A);
    chk("x1_second_wd", int'(second_wd), 'h5B);
    chk("x1_last_wd", int'(last_wd), 'hA5);
    chk("x1_first_addr", int'(first_addr), 'h0200);
    chk("x1_last_addr", int'(last_addr), 'h02FF);
    chk("x1_align", int'(align_cnt), 0);
    chk("x1_done", int'(done_cnt), 1);

    // start in the done cycle is accepted
    dma_start = 1'b1; dma_page = 8'h10;
    tick();
    dma_start = 1'b0;
    chk("done_cycle_start_busy", int'(busy), 1);
    wait_idle();
    tick();

    // HALT on get cycle: one ALIGN
    xfer(8'h02, 1'b0, 0, 0, 1'b0);
    chk("x2_low", int'(low_cnt), 514);
    chk("x2_align", int'(align_cnt), 1);
    chk("x2_first_rd_par", int'(first_rd_par), 0);
    chk("x2_writes", int'(wr_cnt), 256);
    chk("x2_done", int'(done_cnt), 1);
    tick();

    // start re-pulsed at byte 100 and on the final write: ignored
    xfer(8'h44, 1'b1, 100, 0, 1'b0);
    chk("x3_writes", int'(wr_cnt), 256);
    chk("x3_done", int'(done_cnt), 1);
    tick();
    chk("x3_no_restart", int'(busy), 0);

    // reset during write of byte 37
    xfer(8'h05, 1'b1, 0, 37, 1'b0);
    chk("x4_writes_before_rst", int'(wr_cnt), 37);
    chk("x4_rst_cpu_rdy", int'(cpu_rdy), 1);
    chk("x4_rst_busy", int'(busy), 0);
    reset = 1'b0;
    begin
      int unsigned rds = 0;
      for (int i = 0; i < 5; i++) begin
        if (mem_rd) rds++;
        tick();
      end
      chk("x4_no_mem_rd", int'(rds), 0);
    end
    xfer(8'h03, 1'b1, 0, 0, 1'b0);
    chk("x4_fresh_first_addr", int'(first_addr), 'h0300);
    chk("x4_fresh_writes", int'(wr_cnt), 256);
    tick();

    // cpu cs held high: seen in HALT, blocked in READ
    xfer(8'h07, 1'b0, 0, 0, 1'b1);
    chk("x5_halt_cs", int'(halt_cs), 1);
    chk("x5_read_cs", int'(rd_cs_cnt), 0);
    tick();

    for (int r = 0; r < 6; r++) begin
      int unsigned inj, rst;
      inj = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 255) : 0;
      rst = (r == 3) ? $urandom_range(1, 250) : 0;
      xfer(8'($urandom), 1'($urandom), inj, rst, 1'b0);
      reset = 1'b0;
      repeat ($urandom_range(0, 4)) begin rand_cpu(1'b0); tick(); end
    end

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
